mem_access_controller: RTL and testbench
========================================

# mem_access_controller

Sequences every data-RAM transaction the microprogrammed control unit requests. It accepts the MOV/RW/DL request, drives the RAM strobes for a fixed number of wait states, and splits doubleword transfers into two word beats. It captures read data and returns MOC to the control unit's condition mux. It sits between the control unit/MAR/MDR and the RAM.

## Interface
- WAIT_CYCLES, 2: extra RAM cycles per beat; each beat lasts WAIT_CYCLES+1 cycles.
- ADDR_W, 9: RAM address width (512-byte RAM).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- MOV  in  1  memory-operation request from the control unit; held high until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- DL  in  2  data length: 00 byte, 01 halfword, 10 word, 11 doubleword.
- address  in  32  byte address from MAR; only [ADDR_W-1:0] used.
- wr_data  in  64  write data from MDR; [31:0] is beat 0, [63:32] is beat 1.
- ram_rdata  in  32  RAM read data, valid on the last cycle of a read beat.
- ram_en  out  1  RAM strobe.
- ram_rw  out  1  copy of latched RW.
- ram_size  out  2  00 byte, 01 halfword, 10 word; doubleword is issued as 10.
- ram_addr  out  ADDR_W  beat address.
- ram_wdata  out  32  beat write data.
- rd_data  out  64  captured read data.
- MOC  out  1  memory operation complete.
- align_err  out  1  misaligned request flag.

## Operation
- States: IDLE, ACCESS, DONE, ERR. All outputs are registered.
- Reset value of every output is 0. State returns to IDLE; counter, beat and latches clear.
- **IDLE**
  - MOV=1 at an edge latches address, RW, DL and wr_data.
  - Clears beat and loads cnt=WAIT_CYCLES.
  - Moves to ACCESS, or to ERR if misaligned (see Configuration).
- **ACCESS**
  - ram_en=1; ram_addr = latched address + 4·beat, modulo 2^ADDR_W (wraps).
  - cnt decrements each cycle.
  - At cnt==0, if RW=1, ram_rdata is written to rd_data[31:0] (beat 0) or rd_data[63:32] (beat 1).
  - Byte and halfword reads are zero-extended into rd_data[31:0].
  - At cnt==0 with DL=11 and beat=0: beat←1, cnt reloads, stay in ACCESS.
  - Otherwise at cnt==0: go to DONE.
- **DONE**
  - MOC=1, ram_en=0.
  - Stay while MOV=1; a held MOV never retriggers.
  - MOV=0 returns to IDLE; MOC falls in the same cycle as the transition.
- **ERR**
  - align_err=1 and MOC=1 (so the microprogram cannot hang); ram_en stays 0.
  - Exit to IDLE when MOV=0.
- MOV falling during ACCESS is ignored: the transfer, including a second doubleword beat, runs to completion. DONE then lasts exactly one cycle.
- RW, DL, address and wr_data changes after the request is latched have no effect until the next IDLE.
- Reset asserted mid-ACCESS: ram_en and MOC are 0 after that edge. No further beat and no rd_data update occur.

## Timing
- MOV sampled high at edge k gives ram_en high for cycles k+1 … k+1+WAIT_CYCLES.
- Single beat: MOC rises at edge k+WAIT_CYCLES+2. With default WAIT_CYCLES=2, MOC rises at k+4.
- Doubleword: 2·(WAIT_CYCLES+1) contiguous ram_en cycles; MOC rises at k+2·WAIT_CYCLES+3.
- Misaligned (check enabled): MOC and align_err rise at k+1.
- Minimum gap between requests: one IDLE cycle with MOV=0.

## Configuration
- Macro ALIGN_CHECK_EN.
- Defined: misaligned requests go to ERR with no RAM access.
  - Halfword is misaligned when address[0]≠0.
  - Word and doubleword are misaligned when address[1:0]≠0.
- Undefined: no check. The address is passed unchanged, ERR is unreachable and align_err is tied 0.

## Structure
- Shared package mem_ctrl_pkg holds:
  - DL encodings (DL_BYTE, DL_HALF, DL_WORD, DL_DOUBLE);
  - state encodings (S_IDLE, S_ACCESS, S_DONE, S_ERR);
  - the ram_size encodings.
- One sub-module, wait_counter: loadable down-counter with a zero flag, width $clog2(WAIT_CYCLES+1) (minimum 1).

## Test plan
- Word read at 0x010, RAM returns 0xDEADBEEF:
  - ram_en high for 3 cycles with ram_addr=0x010;
  - rd_data[31:0]=0xDEADBEEF;
  - MOC rises 4 cycles after MOV is sampled.
- Doubleword write at 0x1FC, wr_data=0x11112222_33334444:
  - beat 0 at 0x1FC with 0x33334444;
  - beat 1 wraps to 0x000 with 0x11112222;
  - 6 ram_en cycles; MOC at k+7.
- MOV held high 10 cycles after MOC: exactly one transaction, MOC stays high; MOV low returns to IDLE and MOC goes to 0.
- MOV dropped in cycle 2 of a doubleword read: both beats complete, MOC is high for exactly one cycle, then IDLE.
- Reset asserted on cycle 2 of ACCESS: ram_en=0, MOC=0 and rd_data unchanged from the next edge; a new request then proceeds normally.
- With ALIGN_CHECK_EN, word request at 0x013: no ram_en; align_err and MOC high at k+1 until MOV drops. Without the macro, the same request accesses 0x013 normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared data-length, state and RAM-size encodings for mem_access_controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {DL_BYTE = 2'b00, DL_HALF = 2'b01, DL_WORD = 2'b10, DL_DOUBLE = 2'b11} dl_t;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic is_misaligned(input logic [1:0] dl, input logic [1:0] a);
    return dl == DL_HALF ? a[0] : dl[1] ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter with a zero flag, pacing the wait states of each RAM beat
module wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else cnt <= load ? load_val : dec ? cnt - W'(1) : cnt;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: sequences data-RAM beats for MOV/RW/DL requests and returns MOC.
// Define ALIGN_CHECK_EN to trap misaligned halfword/word/doubleword requests in ERR.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        DL,
  input  logic [31:0]       address,
  input  logic [63:0]       wr_data,
  input  logic [31:0]       ram_rdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [1:0]        ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [63:0]       rd_data,
  output logic              MOC,
  output logic              align_err
);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  state_t state, next;
  dl_t lat_dl;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0] lat_wd;
  logic [31:0] ext;
  logic lat_rw, beat, cap, cap_beat, zero;
  logic start, last, dbl_first, load, dec, misaligned, err_n, unused_addr;
  assign unused_addr = ^address[31:ADDR_W];
`ifdef ALIGN_CHECK_EN
  assign misaligned = is_misaligned(DL, address[1:0]);
  assign err_n = state == S_ERR && !(align_err && !MOV);
`else
  assign misaligned = 1'b0;
  assign err_n = 1'b0;
`endif
  wait_counter #(.W(CW)) u_cnt (
    .clk(clk), .reset(reset), .load(load), .dec(dec), .load_val(CW'(WAIT_CYCLES)), .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= next;
  end
  always_comb begin
    start = state == S_IDLE && MOV;
    last = state == S_ACCESS && zero;
    dbl_first = lat_dl == DL_DOUBLE && !beat;
    load = start || last;
    dec = state == S_ACCESS && !zero;
    ext = lat_dl == DL_BYTE ? {24'h0, ram_rdata[7:0]} : lat_dl == DL_HALF ? {16'h0, ram_rdata[15:0]} : ram_rdata;
    next = state == S_IDLE ? (MOV ? (misaligned ? S_ERR : S_ACCESS) : S_IDLE)
         : state == S_ACCESS ? (zero && !dbl_first ? S_DONE : S_ACCESS)
         : MOV ? state : S_IDLE;
  end
  // Outputs trail the state by one edge; read capture lands on the final strobed cycle of a beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr <= '0;
      lat_rw <= 1'b0;
      lat_dl <= DL_BYTE;
      lat_wd <= '0;
      beat <= 1'b0;
      cap <= 1'b0;
      cap_beat <= 1'b0;
      ram_en <= 1'b0;
      ram_rw <= 1'b0;
      ram_size <= '0;
      ram_addr <= '0;
      ram_wdata <= '0;
      rd_data <= '0;
      MOC <= 1'b0;
      align_err <= 1'b0;
    end else begin
      if (start) begin
        lat_addr <= address[ADDR_W-1:0];
        lat_rw <= RW;
        lat_dl <= dl_t'(DL);
        lat_wd <= wr_data;
      end
      beat <= start ? 1'b0 : last && dbl_first ? 1'b1 : beat;
      cap <= last && lat_rw;
      cap_beat <= beat;
      ram_en <= state == S_ACCESS;
      ram_rw <= lat_rw;
      ram_size <= lat_dl == DL_DOUBLE ? SZ_WORD : lat_dl;
      ram_addr <= lat_addr + ADDR_W'({beat, 2'b00});
      ram_wdata <= beat ? lat_wd[63:32] : lat_wd[31:0];
      rd_data <= cap ? (cap_beat ? {ram_rdata, rd_data[31:0]} : {rd_data[63:32], ext}) : rd_data;
      MOC <= (state == S_DONE || state == S_ERR) && !(MOC && !MOV);
      align_err <= err_n;
    end
  end
endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: scoreboard bench for mem_access_controller with a wait-state RAM model
module tb_mem_access_controller;
  import mem_ctrl_pkg::*;
  localparam int W = 2;
  logic clk = 1'b0, reset = 1'b1, MOV = 1'b0, RW = 1'b0;
  logic [1:0] DL = 2'b00;
  logic [31:0] address = '0;
  logic [63:0] wr_data = '0;
  logic [31:0] ram_rdata, ram_wdata;
  logic ram_en, ram_rw, MOC, align_err;
  logic [1:0] ram_size;
  logic [8:0] ram_addr;
  logic [63:0] rd_data;
  int total = 0, bad = 0, en_cycles = 0, run = 0;
  logic [31:0] mem [128];
  typedef struct {logic [8:0] addr; logic [31:0] wdata; logic rw; logic [1:0] size;} beat_t;
  beat_t exp_q[$];
  beat_t e;

  always #5 clk = ~clk;

  mem_access_controller #(.WAIT_CYCLES(W), .ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .DL(DL), .address(address), .wr_data(wr_data),
    .ram_rdata(ram_rdata), .ram_en(ram_en), .ram_rw(ram_rw), .ram_size(ram_size), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .rd_data(rd_data), .MOC(MOC), .align_err(align_err)
  );

  // RAM model: data is only valid on the last strobed cycle of each beat
  always @(posedge clk) run <= ram_en ? (run + 1) % (W + 1) : 0;
  assign ram_rdata = (ram_en && run == W) ? mem[ram_addr[8:2]] : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (ram_en) begin
      en_cycles++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ram_beat unexpected strobe at addr=%h", ram_addr);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.addr || ram_rw !== e.rw || ram_size !== e.size || (!e.rw && ram_wdata !== e.wdata)) begin
          bad++;
          $display("FAIL ram_beat got addr=%h rw=%b size=%b wdata=%h want addr=%h rw=%b size=%b wdata=%h",
                   ram_addr, ram_rw, ram_size, ram_wdata, e.addr, e.rw, e.size, e.wdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] a, input logic [31:0] wd, input logic rw, input logic [1:0] sz, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{a, wd, rw, sz});
  endtask

  task automatic request(input logic rw, input logic [1:0] dl, input logic [31:0] a, input logic [63:0] wd);
    MOV = 1'b1;
    RW = rw;
    DL = dl;
    address = a;
    wr_data = wd;
  endtask

  task automatic wait_moc(output int idx);
    idx = -1;
    for (int i = 0; i < 40 && idx < 0; i++) begin
      tick();
      if (MOC === 1'b1) idx = i;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({ram_en, MOC, align_err, ram_rw} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got en/moc/err/rw=%b want 0000", {ram_en, MOC, align_err, ram_rw});
    end
    total++;
    if (rd_data !== 64'h0 || ram_addr !== 9'h0 || ram_wdata !== 32'h0 || ram_size !== 2'b00) begin
      bad++;
      $display("FAIL reset_data got rd=%h addr=%h wd=%h size=%b want zeros", rd_data, ram_addr, ram_wdata, ram_size);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_word_read();
    int idx;
    en_cycles = 0;
    push(9'h010, 32'h0, 1'b1, SZ_WORD, 3);
    request(1'b1, DL_WORD, 32'h10, 64'h0);
    wait_moc(idx);
    total++;
    if (idx !== 4) begin bad++; $display("FAIL word_read_latency got %0d want 4", idx); end
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL word_read_data got %h want deadbeef", rd_data[31:0]); end
    MOV = 1'b0;
    tick();
    total++;
    if (MOC !== 1'b0) begin bad++; $display("FAIL word_read_moc_fall got %b want 0", MOC); end
    total++;
    if (en_cycles !== 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL word_read_strobes got %0d left=%0d want 3 left=0", en_cycles, exp_q.size());
    end
    tick();
  endtask

  task automatic test_dbl_write();
    int idx;
    en_cycles = 0;
    push(9'h1FC, 32'h33334444, 1'b0, SZ_WORD, 3);
    push(9'h000, 32'h11112222, 1'b0, SZ_WORD, 3);
    request(1'b0, DL_DOUBLE, 32'h1FC, 64'h11112222_33334444);
    tick();
    RW = 1'b1;
    DL = DL_BYTE;
    address = 32'h0AB;
    wr_data = '1;
    wait_moc(idx);
    idx = idx + 1;
    total++;
    if (idx !== 7) begin bad++; $display("FAIL dbl_write_latency got %0d want 7", idx); end
    MOV = 1'b0;
    tick();
    total++;
    if (MOC !== 1'b0) begin bad++; $display("FAIL dbl_write_moc_fall got %b want 0", MOC); end
    total++;
    if (en_cycles !== 6 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL dbl_write_strobes got %0d left=%0d want 6 left=0", en_cycles, exp_q.size());
    end
    tick();
  endtask

  task automatic test_hold_mov();
    int idx, held;
    en_cycles = 0;
    held = 0;
    push(9'h020, 32'hCAFEF00D, 1'b0, SZ_WORD, 3);
    request(1'b0, DL_WORD, 32'h20, 64'h0_CAFEF00D);
    wait_moc(idx);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (MOC === 1'b1) held++;
    end
    total++;
    if (held !== 10) begin bad++; $display("FAIL hold_moc_high got %0d want 10", held); end
    total++;
    if (en_cycles !== 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL hold_single_txn got %0d strobes want 3", en_cycles);
    end
    MOV = 1'b0;
    tick();
    total++;
    if (MOC !== 1'b0) begin bad++; $display("FAIL hold_moc_fall got %b want 0", MOC); end
    tick();
  endtask

  task automatic test_mov_drop();
    int first, highs;
    en_cycles = 0;
    first = -1;
    highs = 0;
    push(9'h040, 32'h0, 1'b1, SZ_WORD, 3);
    push(9'h044, 32'h0, 1'b1, SZ_WORD, 3);
    request(1'b1, DL_DOUBLE, 32'h40, 64'h0);
    tick();
    tick();
    MOV = 1'b0;
    for (int i = 2; i < 16; i++) begin
      tick();
      if (MOC === 1'b1) begin
        highs++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (first !== 7 || highs !== 1) begin bad++; $display("FAIL drop_moc_pulse got first=%0d highs=%0d want 7 1", first, highs); end
    total++;
    if (rd_data !== {mem[17], mem[16]}) begin bad++; $display("FAIL drop_rd_data got %h want %h", rd_data, {mem[17], mem[16]}); end
    total++;
    if (en_cycles !== 6 || exp_q.size() != 0) begin bad++; $display("FAIL drop_strobes got %0d want 6", en_cycles); end
  endtask

  task automatic test_sizes();
    int idx;
    push(9'h041, 32'h0, 1'b1, SZ_BYTE, 3);
    request(1'b1, DL_BYTE, 32'h41, 64'h0);
    wait_moc(idx);
    total++;
    if (idx !== 4 || rd_data[31:0] !== {24'h0, mem[16][7:0]}) begin
      bad++;
      $display("FAIL byte_read got lat=%0d data=%h want 4 %h", idx, rd_data[31:0], {24'h0, mem[16][7:0]});
    end
    MOV = 1'b0;
    tick();
    tick();
    push(9'h022, 32'h0, 1'b1, SZ_HALF, 3);
    request(1'b1, DL_HALF, 32'h22, 64'h0);
    wait_moc(idx);
    total++;
    if (idx !== 4 || rd_data[31:0] !== {16'h0, mem[8][15:0]}) begin
      bad++;
      $display("FAIL half_read got lat=%0d data=%h want 4 %h", idx, rd_data[31:0], {16'h0, mem[8][15:0]});
    end
    MOV = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int idx, quiet;
    en_cycles = 0;
    quiet = 0;
    push(9'h060, 32'h0, 1'b1, SZ_WORD, 1);
    request(1'b1, DL_WORD, 32'h60, 64'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (ram_en !== 1'b0 || MOC !== 1'b0 || rd_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_mid got en=%b moc=%b rd=%h want 0 0 0", ram_en, MOC, rd_data);
    end
    reset = 1'b0;
    MOV = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ram_en === 1'b0 && MOC === 1'b0 && rd_data === 64'h0) quiet++;
    end
    total++;
    if (quiet !== 5 || en_cycles !== 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet got quiet=%0d strobes=%0d want 5 1", quiet, en_cycles);
    end
    push(9'h070, 32'h0, 1'b1, SZ_WORD, 3);
    request(1'b1, DL_WORD, 32'h70, 64'h0);
    wait_moc(idx);
    total++;
    if (idx !== 4 || rd_data[31:0] !== mem[28]) begin
      bad++;
      $display("FAIL reset_mid_recover got lat=%0d data=%h want 4 %h", idx, rd_data[31:0], mem[28]);
    end
    MOV = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int idx0, idx1;
    push(9'h010, 32'h0, 1'b1, SZ_WORD, 3);
    request(1'b1, DL_WORD, 32'h10, 64'h0);
    wait_moc(idx0);
    MOV = 1'b0;
    tick();
    tick();
    push(9'h014, 32'h0, 1'b1, SZ_WORD, 3);
    request(1'b1, DL_WORD, 32'h14, 64'h0);
    wait_moc(idx1);
    total++;
    if (idx0 !== 4 || idx1 !== 4 || rd_data[31:0] !== mem[5]) begin
      bad++;
      $display("FAIL back_to_back got lat=%0d/%0d data=%h want 4/4 %h", idx0, idx1, rd_data[31:0], mem[5]);
    end
    MOV = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_misaligned();
    int idx, held;
    en_cycles = 0;
    held = 0;
`ifdef ALIGN_CHECK_EN
    request(1'b1, DL_WORD, 32'h13, 64'h0);
    wait_moc(idx);
    total++;
    if (idx !== 1 || align_err !== 1'b1) begin bad++; $display("FAIL misaligned_trap got lat=%0d err=%b want 1 1", idx, align_err); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (MOC === 1'b1 && align_err === 1'b1) held++;
    end
    total++;
    if (held !== 4 || en_cycles !== 0) begin bad++; $display("FAIL misaligned_hold got held=%0d strobes=%0d want 4 0", held, en_cycles); end
    MOV = 1'b0;
    tick();
    total++;
    if (MOC !== 1'b0 || align_err !== 1'b0) begin bad++; $display("FAIL misaligned_exit got moc=%b err=%b want 0 0", MOC, align_err); end
`else
    push(9'h013, 32'h0, 1'b1, SZ_WORD, 3);
    request(1'b1, DL_WORD, 32'h13, 64'h0);
    wait_moc(idx);
    total++;
    if (idx !== 4 || align_err !== 1'b0 || rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL unaligned_pass got lat=%0d err=%b data=%h want 4 0 deadbeef", idx, align_err, rd_data[31:0]);
    end
    MOV = 1'b0;
    tick();
    total++;
    if (MOC !== 1'b0 || en_cycles !== 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL unaligned_exit got moc=%b strobes=%0d want 0 3", MOC, en_cycles);
    end
`endif
    tick();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA0B0C0D0 ^ {4{8'(i)}};
    mem[4] = 32'hDEADBEEF;
    test_reset();
    test_word_read();
    test_dbl_write();
    test_hold_mov();
    test_mov_drop();
    test_sizes();
    test_reset_mid();
    test_back_to_back();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
